// File: rtl/cfa_pass_sequencer.sv
// Multi-pass raster sequencer for the CFA demosaic datapath: issues read addresses and
// Bayer phase per pass, and emits latency-aligned per-channel write strobes.
module cfa_pass_sequencer #(
  parameter int ROW_W      = 11,
  parameter int COL_W      = 11,
  parameter int ADDR_W     = 17,
  parameter int NUM_PASSES = 3,
  parameter int NUM_CH     = 3,
  parameter int PIPE_LAT   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         stall,
  input  logic [ROW_W-1:0]             row_max,
  input  logic [COL_W-1:0]             col_max,
  input  logic [1:0]                   pattern_sel,
  input  logic [NUM_PASSES*3*NUM_CH-1:0] wen_mask,
  output logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_valid,
  output logic [ROW_W-1:0]             row,
  output logic [COL_W-1:0]             col,
  output logic [1:0]                   bayer_sym,
  output logic [1:0]                   pass_idx,
  output logic                         pass_start,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [1:0]                   wr_sym,
  output logic [NUM_CH-1:0]            wr_en,
  output logic                         busy,
  output logic                         done
);

  // state  | meaning
  // S_IDLE | waiting for start, outputs inactive
  // S_SCAN | issuing one pixel per unstalled cycle
  // S_DRAIN| no issue, waiting for the delay pipeline to empty
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  localparam int MASK_W = NUM_PASSES * 3 * NUM_CH;
  localparam logic [1:0] LAST_PASS = 2'(NUM_PASSES - 1);

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d, row_max_q, row_max_d;
  logic [COL_W-1:0]    col_q, col_d, col_max_q, col_max_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [1:0]          pass_q, pass_d, pat_q, pat_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic                done_q, done_d;

  logic                pv_q [PIPE_LAT];
  logic                pv_d [PIPE_LAT];
  logic [ADDR_W-1:0]   pa_q [PIPE_LAT];
  logic [ADDR_W-1:0]   pa_d [PIPE_LAT];
  logic [1:0]          ps_q [PIPE_LAT];
  logic [1:0]          ps_d [PIPE_LAT];
  logic [1:0]          pp_q [PIPE_LAT];
  logic [1:0]          pp_d [PIPE_LAT];

  logic                issue, last_pix, drain_empty;
  logic [1:0]          sym_cur;
  logic [NUM_CH-1:0]   sel_mask;

  // Abort wins over issue so an aborted cycle never launches a read it cannot complete.
  assign issue    = (state_q == S_SCAN) && !stall && !abort;
  assign last_pix = (row_q == row_max_q) && (col_q == col_max_q);

  // pattern_sel encodes the red site as {row parity, col parity}; green sits on the
  // opposite diagonal parity, blue shares red's diagonal.
  always_comb begin
    sym_cur = 2'b01;
    if ((row_q[0] ^ col_q[0]) == (pat_q[1] ^ pat_q[0])) begin
      sym_cur = (row_q[0] == pat_q[1]) ? 2'b10 : 2'b11;
    end
  end

  // The tail may still hold data: it leaves on this cycle's shift.
  always_comb begin
    drain_empty = 1'b1;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      if (pv_q[i]) drain_empty = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    rd_addr_d = rd_addr_q;
    pass_d    = pass_q;
    row_max_d = row_max_q;
    col_max_d = col_max_q;
    pat_d     = pat_q;
    mask_d    = mask_q;
    done_d    = 1'b0;
    pv_d      = pv_q;
    pa_d      = pa_q;
    ps_d      = ps_q;
    pp_d      = pp_q;

    if (abort) begin
      state_d   = S_IDLE;
      row_d     = '0;
      col_d     = '0;
      rd_addr_d = '0;
      pass_d    = '0;
      for (int i = 0; i < PIPE_LAT; i++) pv_d[i] = 1'b0;
    end else begin
      if (!stall) begin
        pv_d[0] = issue;
        pa_d[0] = rd_addr_q;
        ps_d[0] = sym_cur;
        pp_d[0] = pass_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
          pv_d[i] = pv_q[i-1];
          pa_d[i] = pa_q[i-1];
          ps_d[i] = ps_q[i-1];
          pp_d[i] = pp_q[i-1];
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_SCAN;
            row_d     = '0;
            col_d     = '0;
            rd_addr_d = '0;
            pass_d    = '0;
            row_max_d = row_max;
            col_max_d = col_max;
            pat_d     = pattern_sel;
            mask_d    = wen_mask;
          end
        end
        S_SCAN: begin
          if (!stall) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            if (col_q == col_max_q) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
            if (last_pix) begin
              state_d   = S_DRAIN;
              row_d     = '0;
              col_d     = '0;
              rd_addr_d = '0;
            end
          end
        end
        S_DRAIN: begin
          if (!stall && drain_empty) begin
            if (pass_q != LAST_PASS) begin
              pass_d  = pass_q + 2'd1;
              state_d = S_SCAN;
            end else begin
              pass_d  = '0;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      rd_addr_q <= '0;
      pass_q    <= '0;
      row_max_q <= '0;
      col_max_q <= '0;
      pat_q     <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
        ps_q[i] <= '0;
        pp_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rd_addr_q <= rd_addr_d;
      pass_q    <= pass_d;
      row_max_q <= row_max_d;
      col_max_q <= col_max_d;
      pat_q     <= pat_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      pv_q      <= pv_d;
      pa_q      <= pa_d;
      ps_q      <= ps_d;
      pp_q      <= pp_d;
    end
  end

  always_comb begin
    sel_mask = '0;
    for (int p = 0; p < NUM_PASSES; p++) begin
      for (int s = 1; s <= 3; s++) begin
        if (pp_q[PIPE_LAT-1] == 2'(p) && ps_q[PIPE_LAT-1] == 2'(s)) begin
          sel_mask = mask_q[(p*3 + s - 1)*NUM_CH +: NUM_CH];
        end
      end
    end
    wr_en = (pv_q[PIPE_LAT-1] && !stall) ? sel_mask : '0;
  end

  assign rd_valid   = issue;
  assign rd_addr    = rd_addr_q;
  assign row        = row_q;
  assign col        = col_q;
  assign bayer_sym  = (state_q == S_SCAN) ? sym_cur : 2'b00;
  assign pass_idx   = pass_q;
  assign pass_start = issue && (row_q == '0) && (col_q == '0);
  assign wr_addr    = pa_q[PIPE_LAT-1];
  assign wr_sym     = ps_q[PIPE_LAT-1];
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_cfa_pass_sequencer.sv
// Scoreboard bench for cfa_pass_sequencer: directed frames push expected reads/writes,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_cfa_pass_sequencer;

  logic        clk, rst, start, abort, stall;
  logic [10:0] row_max, col_max;
  logic [1:0]  pattern_sel;
  logic [26:0] wen_mask;
  logic [16:0] rd_addr, wr_addr;
  logic        rd_valid, pass_start, busy, done;
  logic [10:0] row, col;
  logic [1:0]  bayer_sym, pass_idx, wr_sym;
  logic [2:0]  wr_en;

  cfa_pass_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .row_max(row_max), .col_max(col_max), .pattern_sel(pattern_sel), .wen_mask(wen_mask),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .row(row), .col(col), .bayer_sym(bayer_sym),
    .pass_idx(pass_idx), .pass_start(pass_start), .wr_addr(wr_addr), .wr_sym(wr_sym),
    .wr_en(wr_en), .busy(busy), .done(done)
  );

  typedef struct { int addr; int row; int col; int sym; int pass; int ps; int cyc; } rd_t;
  typedef struct { int addr; int sym; int wen; int cyc; } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  rd_t re;
  wr_t we;

  int n_vec = 0, n_err = 0;
  int cyc = 0, t0 = 0, exp_done = -1, n_done = 0, nd_start = 0, rel;

  // Hand table: symbol at (row parity, col parity) in raster order per pattern.
  int symtab [16] = '{2, 1, 1, 3,   1, 2, 3, 1,   1, 3, 2, 1,   3, 1, 1, 2};
  logic [26:0] all_ones = '1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: no finish, miscompares so far %0d", n_err);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sh(input int c, input int st_at, input int st_len);
    return (st_len > 0 && c >= st_at) ? c + st_len : c;
  endfunction

  task automatic push_frame(input int rows, input int cols, input int pat, input logic [26:0] m,
                            input int st_at, input int st_len, input int cut_rd,
                            input int cut_wr, input bit want_done);
    int n, nom, r, c, s, w;
    rd_t rx;
    wr_t wx;
    n = rows * cols;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < n; i++) begin
        r   = i / cols;
        c   = i % cols;
        s   = symtab[pat*4 + (r%2)*2 + (c%2)];
        nom = 1 + k*(n + 3) + i;
        if (nom < cut_rd) begin
          rx = '{i, r, c, s, k, (i == 0) ? 1 : 0, sh(nom, st_at, st_len)};
          rd_q.push_back(rx);
        end
        w = int'(m[(k*3 + s - 1)*3 +: 3]);
        if (w != 0 && nom + 3 < cut_wr) begin
          wx = '{i, s, w, sh(nom + 3, st_at, st_len)};
          wr_q.push_back(wx);
        end
      end
    end
    exp_done = want_done ? sh(3*(n + 3) + 1, st_at, st_len) : -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is positioned just after a rising edge; that cycle becomes cycle 0.
  task automatic launch(input int rm, input int cm, input int pat, input logic [26:0] m);
    row_max     = 11'(rm);
    col_max     = 11'(cm);
    pattern_sel = 2'(pat);
    wen_mask    = m;
    start       = 1'b1;
    t0          = cyc;
    nd_start    = n_done;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_frame();
    int budget;
    budget = 0;
    while (n_done == nd_start && budget < 400) begin
      tick();
      budget++;
    end
    if (n_done == nd_start) chk("done_timeout", 0, 1);
    repeat (5) tick();
    chk("rd_q_left", rd_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);
    chk("done_count", n_done - nd_start, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      rel = cyc - t0;
      if (rd_valid) begin
        if (rd_q.size() == 0) chk("rd_unexpected", int'(rd_addr), -1);
        else begin
          re = rd_q.pop_front();
          chk("rd_addr", int'(rd_addr), re.addr);
          chk("rd_row", int'(row), re.row);
          chk("rd_col", int'(col), re.col);
          chk("rd_sym", int'(bayer_sym), re.sym);
          chk("rd_pass", int'(pass_idx), re.pass);
          chk("pass_start", int'(pass_start), re.ps);
          chk("rd_cycle", rel, re.cyc);
        end
      end else if (pass_start) chk("pass_start_idle", 1, 0);
      if (wr_en != 3'b000) begin
        if (wr_q.size() == 0) chk("wr_unexpected", int'(wr_addr), -1);
        else begin
          we = wr_q.pop_front();
          chk("wr_addr", int'(wr_addr), we.addr);
          chk("wr_sym", int'(wr_sym), we.sym);
          chk("wr_en", int'(wr_en), we.wen);
          chk("wr_cycle", rel, we.cyc);
        end
      end
      if (stall) begin
        chk("stall_rd_valid", int'(rd_valid), 0);
        chk("stall_wr_en", int'(wr_en), 0);
      end
      if (done) begin
        n_done++;
        chk("done_cycle", rel, exp_done);
        chk("done_busy", int'(busy), 0);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    row_max = '0; col_max = '0; pattern_sel = '0; wen_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_row_col", int'({row, col}), 0);
    chk("rst_sym_pass", int'({bayer_sym, pass_idx, wr_sym}), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_strobes", int'({rd_valid, pass_start, wr_en, busy, done}), 0);
    tick();
    rst = 1'b0;
    tick();

    // 4x4 RGGB, all channels enabled, free-running
    push_frame(4, 4, 0, all_ones, 0, 0, 1 << 30, 1 << 30, 1'b1);
    launch(3, 3, 0, all_ones);
    @(negedge clk);
    chk("busy_run", int'(busy), 1);
    finish_frame();

    // Bayer pattern sweep on 2x2
    for (int p = 0; p < 4; p++) begin
      push_frame(2, 2, p, all_ones, 0, 0, 1 << 30, 1 << 30, 1'b1);
      launch(1, 1, p, all_ones);
      finish_frame();
    end

    // Only green write at red sites in pass 0
    push_frame(4, 4, 0, 27'h8, 0, 0, 1 << 30, 1 << 30, 1'b1);
    launch(3, 3, 0, 27'h8);
    finish_frame();

    // Five stalled cycles starting at cycle 7
    push_frame(4, 4, 0, all_ones, 7, 5, 1 << 30, 1 << 30, 1'b1);
    launch(3, 3, 0, all_ones);
    while (cyc - t0 < 7) tick();
    stall = 1'b1;
    repeat (5) tick();
    stall = 1'b0;
    finish_frame();

    // Abort at cycle 25, restart at cycle 30
    push_frame(4, 4, 0, all_ones, 0, 0, 25, 26, 1'b0);
    launch(3, 3, 0, all_ones);
    while (cyc - t0 < 25) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    while (cyc - t0 < 30) begin
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_wr_en", int'(wr_en), 0);
      tick();
    end
    chk("abort_rd_q_left", rd_q.size(), 0);
    chk("abort_wr_q_left", wr_q.size(), 0);
    chk("abort_no_done", n_done - nd_start, 0);
    push_frame(4, 4, 0, all_ones, 0, 0, 1 << 30, 1 << 30, 1'b1);
    launch(3, 3, 0, all_ones);
    finish_frame();

    // start pulses while busy are ignored
    push_frame(4, 4, 0, all_ones, 0, 0, 1 << 30, 1 << 30, 1'b1);
    launch(3, 3, 0, all_ones);
    while (cyc - t0 < 5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc - t0 < 40) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
